// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end.
// Holds the fetch PC, runs the req/ack handshake with instruction memory,
// applies jump/branch redirects (jump wins) and presents one instruction
// at a time to decode with stall back-pressure.
// Optional feature macro: PC_ALIGN_CHECK_EN. When defined, a misaligned
// redirect target is replaced by EXC_VECTOR and addr_err_o pulses for one
// cycle. When undefined, targets are used as-is and addr_err_o is tied 0.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_plus4_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] inst_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        addr_err_o
);

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pend_q;      // redirect target waiting for the squashed ack
  logic        out_q;       // a request was issued and is still unacked
  logic        free;
  logic        redir;
  logic        mis;
  logic [31:0] tgt;
  logic        ack_eff;
  logic        in_flight;   // request active this cycle and not acked

  // Jump beats branch; a misaligned target may be swapped for the vector.
  function automatic logic [31:0] select_target(input logic        jmp,
                                                input logic [31:0] jt,
                                                input logic [31:0] bt,
                                                input logic        bad);
    logic [31:0] t;
    t = jmp ? jt : bt;
    if (ALIGN_CHK && bad) t = EXC_VECTOR;
    return t;
  endfunction

  // Redirect decode and handshake qualifiers.
  always_comb begin
    logic [31:0] raw;
    raw       = jump_i ? jump_target_i : branch_target_i;
    mis       = (raw[1:0] != 2'b00);
    redir     = jump_i || branch_i;
    tgt       = select_target(jump_i, jump_target_i, branch_target_i, mis);
    free      = !inst_valid_o || !stall_i;
    ack_eff   = imem_ack_i && imem_req_o;
    in_flight = imem_req_o && !imem_ack_i;
  end

  // Next-state and request generation.
  always_comb begin
    state_nxt  = state;
    imem_req_o = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = RUN;
      end
      RUN: begin
        // An issued request holds until acked, even if the slot fills.
        imem_req_o = out_q || free;
        if (redir && imem_req_o && !imem_ack_i) state_nxt = SQUASH;
      end
      SQUASH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) state_nxt = RUN;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // PC, pending target, outstanding flag and decode slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o         <= RESET_PC;
      pend_q       <= 32'h0;
      out_q        <= 1'b0;
      inst_o       <= 32'h0;
      inst_pc_o    <= 32'h0;
      inst_valid_o <= 1'b0;
    end else begin
      out_q <= in_flight;
      case (state)
        RUN: begin
          if (redir) begin
            inst_valid_o <= 1'b0;
            if (in_flight) pend_q <= tgt;
            else           pc_o   <= tgt;
          end else if (ack_eff) begin
            inst_o       <= inst_i;
            inst_pc_o    <= pc_o;
            inst_valid_o <= 1'b1;
            pc_o         <= pc_plus4_i;
          end else if (inst_valid_o && !stall_i) begin
            inst_valid_o <= 1'b0;
          end
        end
        SQUASH: begin
          inst_valid_o <= 1'b0;
          if (redir) pend_q <= tgt;
          // Latest redirect wins, including one arriving with the ack.
          if (imem_ack_i) pc_o <= redir ? tgt : pend_q;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // One-cycle error pulse after any accepted misaligned redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_err_o <= 1'b0;
    else        addr_err_o <= (state != IDLE) && redir && mis;
  end
`else
  assign addr_err_o = 1'b0;
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end of the single-issue CPU.
- Holds the program counter and drives it to the PC+4 adder and to instruction memory.
- Consumes the adder's PC+4 result as the sequential next address.
- Applies branch/jump redirects, runs a req/ack handshake with instruction memory, and presents one fetched instruction at a time to decode, with stall back-pressure.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0040, substitute fetch address for a misaligned redirect (used only with PC_ALIGN_CHECK_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_o  output  32  current fetch PC; feeds adder cin_a and imem address.
- pc_plus4_i  input  32  adder result (pc_o + 4), combinational return.
- imem_req_o  output  1  fetch request to instruction memory.
- imem_ack_i  input  1  memory has returned inst_i for the current request.
- inst_i  input  32  instruction data from memory, valid with imem_ack_i.
- inst_o  output  32  instruction presented to decode.
- inst_pc_o  output  32  PC of inst_o.
- inst_valid_o  output  1  inst_o/inst_pc_o are valid.
- stall_i  input  1  decode cannot accept; slot held.
- branch_i  input  1  branch-taken redirect pulse.
- branch_target_i  input  32  branch destination.
- jump_i  input  1  jump redirect pulse.
- jump_target_i  input  32  jump destination.
- addr_err_o  output  1  misaligned-redirect flag (feature-dependent).

Behaviour:
- Reset (rst_n low, asynchronous): pc_o=RESET_PC, imem_req_o=0, inst_o=0, inst_pc_o=0, inst_valid_o=0, addr_err_o=0, pending target=0, state=IDLE.
- FSM states:
  - IDLE: req=0. Always moves to RUN on the next cycle. Redirects are ignored.
  - RUN: normal fetch.
  - SQUASH: a redirect arrived while a request was outstanding.
- Slot free condition: `free = !inst_valid_o || !stall_i`.
- RUN, fetch: imem_req_o=1 whenever free.
  - Once asserted, req and pc_o hold stable until imem_ack_i.
  - On ack with no redirect: inst_o<=inst_i, inst_pc_o<=pc_o, inst_valid_o<=1, pc_o<=pc_plus4_i.
  - Latency: inst_valid_o rises 1 cycle after the ack cycle. Zero-wait memory (ack in the same cycle as req) gives 1 instruction per cycle.
- Consumption: decode takes the instruction when inst_valid_o && !stall_i.
  - If consumed and there is no ack that cycle, inst_valid_o<=0.
  - While stalled, inst_o, inst_pc_o and inst_valid_o hold.
- Redirect selection: jump_i has priority over branch_i, giving target T. A redirect has priority over stall and over a concurrent ack.
- Redirect, any cycle in RUN:
  - inst_valid_o<=0 (wrong-path instruction killed).
  - No outstanding request, or ack in the same cycle: pc_o<=T, stay RUN. Ack data is dropped.
  - Outstanding request not yet acked: latch T as pending, go to SQUASH. pc_o and req are unchanged.
- SQUASH:
  - req stays 1 and pc_o is unchanged.
  - On ack: data is discarded, pc_o<=pending, go to RUN.
  - A new redirect in SQUASH overwrites pending (latest wins).
  - inst_valid_o stays 0.
- Arithmetic: pc_plus4_i is used unmodified. Wrap 32'hFFFF_FFFC -> 32'h0000_0000 is legal and needs no special handling.
- Reset mid-request: the outstanding request is abandoned. After reset, the first fetch is from RESET_PC.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Any accepted redirect with T[1:0]!=2'b00 pulses addr_err_o for exactly 1 cycle, the cycle after the redirect.
  - EXC_VECTOR is used in place of T, both for the immediate load and for the pending value.
- Undefined: addr_err_o is tied 0 and T is used as-is.

Test Plan:
- Reset release, zero-wait memory (ack=req), stall_i=0 -> pc_o sequence 0,4,8,C; inst_valid_o=1 from cycle 2; inst_pc_o trails pc_o by one fetch.
- Memory with 2-cycle ack latency, pc_o=0x10 -> imem_req_o and pc_o=0x10 held 2 cycles; inst_o=inst_i 1 cycle after ack; pc_o becomes 0x14.
- stall_i=1 for 3 cycles with inst_valid_o=1, inst_pc_o=0x20 -> inst_o/inst_pc_o unchanged; imem_req_o=0; resumes fetching 0x24 after stall drops.
- Outstanding request at 0x30, branch_i=1 with target 0x100, ack 2 cycles later -> state SQUASH; returned data discarded; inst_valid_o=0; next request at 0x100.
- jump_i and branch_i in the same cycle (targets 0x200 and 0x300) -> pc_o=0x200.
- With PC_ALIGN_CHECK_EN: jump to 0x202 -> addr_err_o pulses 1 cycle and pc_o=0x40. Without the macro -> addr_err_o=0 and pc_o=0x202.
